// File: rtl/fnd_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed FND scan: filters strobe/segment pairs,
// decodes segment codes back to BCD digits and decimal points, and assembles complete frames.
module fnd_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fnd_digit,
  input  logic [7:0]  fnd_data,
  output logic [15:0] digits,
  output logic [3:0]  dots,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        scan_lost
);

  localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ARM  = STAB_W'(STABLE_CYCLES - 2);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    SEG_DIGIT,
    SEG_DOT_ON,
    SEG_DOT_OFF,
    SEG_BAD
  } seg_kind_e;

  logic [3:0]        digit_in_q, digit_in_d;
  logic [7:0]        data_in_q, data_in_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              acc_valid_q, acc_valid_d;
  logic [3:0]        acc_digit_q, acc_digit_d;
  logic [7:0]        acc_data_q, acc_data_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]        seen_q, seen_d;
  logic              err_pend_q, err_pend_d;
  logic [15:0]       digits_q, digits_d;
  logic [3:0]        dots_q, dots_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              scan_lost_q, scan_lost_d;

  logic              pair_changed;
  logic              pos_ok;
  logic [1:0]        pos;
  seg_kind_e         seg_kind;
  logic [3:0]        seg_value;

  // Input register and stability filter; one accept fires per stable pair.
  always_comb begin
    digit_in_d   = fnd_digit;
    data_in_d    = fnd_data;
    pair_changed = ({fnd_digit, fnd_data} != {digit_in_q, data_in_q});
    stab_cnt_d   = stab_cnt_q;
    if (pair_changed) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_LAST) begin
      stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end
    acc_valid_d = !pair_changed && (stab_cnt_q == STAB_ARM);
    acc_digit_d = digit_in_q;
    acc_data_d  = data_in_q;
  end

  always_comb begin
    pos_ok = 1'b1;
    pos    = 2'd0;
    case (acc_digit_q)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos_ok = 1'b0;
    endcase
  end

  always_comb begin
    seg_kind  = SEG_DIGIT;
    seg_value = 4'd0;
    case (acc_data_q)
      8'hC0: seg_value = 4'd0;
      8'hF9: seg_value = 4'd1;
      8'hA4: seg_value = 4'd2;
      8'hB0: seg_value = 4'd3;
      8'h99: seg_value = 4'd4;
      8'h92: seg_value = 4'd5;
      8'h82: seg_value = 4'd6;
      8'hF8: seg_value = 4'd7;
      8'h80: seg_value = 4'd8;
      8'h90: seg_value = 4'd9;
      8'h7F: seg_kind  = SEG_DOT_ON;
      8'hFF: seg_kind  = SEG_DOT_OFF;
      default: seg_kind = SEG_BAD;
    endcase
  end

  // Frame assembly and scan timeout; a valid accept takes priority over the terminal count.
  always_comb begin
    logic [3:0] seen_next;
    digits_d      = digits_q;
    dots_d        = dots_q;
    seen_d        = seen_q;
    err_pend_d    = err_pend_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    scan_lost_d   = scan_lost_q;
    to_cnt_d      = to_cnt_q;
    seen_next     = seen_q | (4'b0001 << pos);

    if (acc_valid_q && pos_ok) begin
      to_cnt_d    = '0;
      scan_lost_d = 1'b0;
      case (seg_kind)
        SEG_DIGIT: begin
          digits_d[{pos, 2'b00} +: 4] = seg_value;
          if (seen_next == 4'b1111) begin
            frame_valid_d = 1'b1;
            frame_err_d   = err_pend_q;
            seen_d        = 4'b0000;
            err_pend_d    = 1'b0;
          end else begin
            seen_d = seen_next;
          end
        end
        SEG_DOT_ON:  dots_d[pos] = 1'b1;
        SEG_DOT_OFF: dots_d[pos] = 1'b0;
        default:     err_pend_d  = 1'b1;
      endcase
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_LIMIT - TO_W'(1)) begin
        scan_lost_d = 1'b1;
        seen_d      = 4'b0000;
        err_pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_in_q    <= 4'hF;
      data_in_q     <= 8'hFF;
      stab_cnt_q    <= '0;
      acc_valid_q   <= 1'b0;
      acc_digit_q   <= 4'hF;
      acc_data_q    <= 8'hFF;
      to_cnt_q      <= '0;
      seen_q        <= 4'b0000;
      err_pend_q    <= 1'b0;
      digits_q      <= 16'h0000;
      dots_q        <= 4'b0000;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      scan_lost_q   <= 1'b0;
    end else begin
      digit_in_q    <= digit_in_d;
      data_in_q     <= data_in_d;
      stab_cnt_q    <= stab_cnt_d;
      acc_valid_q   <= acc_valid_d;
      acc_digit_q   <= acc_digit_d;
      acc_data_q    <= acc_data_d;
      to_cnt_q      <= to_cnt_d;
      seen_q        <= seen_d;
      err_pend_q    <= err_pend_d;
      digits_q      <= digits_d;
      dots_q        <= dots_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      scan_lost_q   <= scan_lost_d;
    end
  end

  assign digits      = digits_q;
  assign dots        = dots_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign scan_lost   = scan_lost_q;

endmodule
